// File: rtl/fwd_sel_stage.sv
// Operand forwarding select stage: registers the MUX8 select/enable for both
// ALU operands and inserts a one-cycle bubble on a load-use hazard.
module fwd_sel_stage #(
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   id_imm_b,
   input  logic                   id_shamt_a,
   input  logic                   ex_wr,
   input  logic                   ex_is_load,
   input  logic [4:0]             ex_rd,
   input  logic                   mem_wr,
   input  logic [4:0]             mem_rd,
   input  logic                   wb_wr,
   input  logic [4:0]             wb_rd,
   input  logic                   flush,
   output logic [2:0]             sel_a,
   output logic [2:0]             sel_b,
   output logic                   dis_a,
   output logic                   dis_b,
   output logic                   ex_valid,
   output logic                   stall_out,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [2:0] SEL_RF    = 3'b000;
   localparam logic [2:0] SEL_EX    = 3'b001;
   localparam logic [2:0] SEL_MEM   = 3'b010;
   localparam logic [2:0] SEL_WB    = 3'b011;
   localparam logic [2:0] SEL_IMM   = 3'b100;
   localparam logic [2:0] SEL_SHAMT = 3'b101;

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] fwd_a_c;
   logic [2:0] fwd_b_c;
   logic       dep_a_c;
   logic       dep_b_c;
   logic       hazard_c;
   logic       cnt_inc_c;
   logic [2:0] sel_a_nxt;
   logic [2:0] sel_b_nxt;
   logic       dis_a_nxt;
   logic       dis_b_nxt;
   logic       ex_valid_nxt;

   // Forward source for operand A: youngest producer wins, r0 never forwarded.
   always_comb begin
      fwd_a_c = SEL_RF;
      if (id_rs != 5'd0) begin
         if (ex_wr && (ex_rd == id_rs))        fwd_a_c = SEL_EX;
         else if (mem_wr && (mem_rd == id_rs)) fwd_a_c = SEL_MEM;
         else if (wb_wr && (wb_rd == id_rs))   fwd_a_c = SEL_WB;
      end
   end

   // Forward source for operand B: same priority as operand A.
   always_comb begin
      fwd_b_c = SEL_RF;
      if (id_rt != 5'd0) begin
         if (ex_wr && (ex_rd == id_rt))        fwd_b_c = SEL_EX;
         else if (mem_wr && (mem_rd == id_rt)) fwd_b_c = SEL_MEM;
         else if (wb_wr && (wb_rd == id_rt))   fwd_b_c = SEL_WB;
      end
   end

   // Load-use detection; overridden operands do not read the register file.
   always_comb begin
      dep_a_c   = id_uses_rs && !id_shamt_a && (id_rs != 5'd0) && (id_rs == ex_rd);
      dep_b_c   = id_uses_rt && !id_imm_b   && (id_rt != 5'd0) && (id_rt == ex_rd);
      hazard_c  = (state == RUN) && id_valid && ex_wr && ex_is_load && (dep_a_c || dep_b_c);
      stall_out = rst_n && hazard_c && !flush;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // Next state and next registered operand controls; bubble is the default.
   always_comb begin
      state_nxt    = state;
      cnt_inc_c    = 1'b0;
      ex_valid_nxt = 1'b0;
      sel_a_nxt    = SEL_RF;
      sel_b_nxt    = SEL_RF;
      dis_a_nxt    = 1'b1;
      dis_b_nxt    = 1'b1;
      case (state)
         RUN: begin
            if (hazard_c && !flush) begin
               state_nxt = STALL;
               cnt_inc_c = 1'b1;
            end
         end
         STALL:   state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      if (!flush && id_valid && !hazard_c) begin
         ex_valid_nxt = 1'b1;
         if (id_shamt_a) begin
            sel_a_nxt = SEL_SHAMT;
            dis_a_nxt = 1'b0;
         end else if (id_uses_rs) begin
            sel_a_nxt = fwd_a_c;
            dis_a_nxt = 1'b0;
         end
         if (id_imm_b) begin
            sel_b_nxt = SEL_IMM;
            dis_b_nxt = 1'b0;
         end else if (id_uses_rt) begin
            sel_b_nxt = fwd_b_c;
            dis_b_nxt = 1'b0;
         end
      end
   end

   // Registered MUX8 controls and EX valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_a    <= SEL_RF;
         sel_b    <= SEL_RF;
         dis_a    <= 1'b1;
         dis_b    <= 1'b1;
         ex_valid <= 1'b0;
      end else begin
         sel_a    <= sel_a_nxt;
         sel_b    <= sel_b_nxt;
         dis_a    <= dis_a_nxt;
         dis_b    <= dis_b_nxt;
         ex_valid <= ex_valid_nxt;
      end
   end

   // Saturating load-use stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          stall_cnt <= '0;
      else if (cnt_inc_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_sel_stage.sv
// Randomized and directed bench for fwd_sel_stage against a behavioural model.
module tb_fwd_sel_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_uses_rs, id_uses_rt, id_imm_b, id_shamt_a;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic       ex_wr, ex_is_load, mem_wr, wb_wr, flush;
   logic [2:0] sel_a, sel_b, sel_a2, sel_b2;
   logic       dis_a, dis_b, ex_valid, stall_out;
   logic       dis_a2, dis_b2, ex_valid2, stall_out2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   bit m_stall;
   int m_cnt, m_cnt2;

   always #5 clk = ~clk;

   fwd_sel_stage u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_imm_b(id_imm_b),
      .id_shamt_a(id_shamt_a), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .wb_wr(wb_wr), .wb_rd(wb_rd), .flush(flush),
      .sel_a(sel_a), .sel_b(sel_b), .dis_a(dis_a), .dis_b(dis_b), .ex_valid(ex_valid),
      .stall_out(stall_out), .stall_cnt(stall_cnt)
   );

   fwd_sel_stage #(.STALL_CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_imm_b(id_imm_b),
      .id_shamt_a(id_shamt_a), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .wb_wr(wb_wr), .wb_rd(wb_rd), .flush(flush),
      .sel_a(sel_a2), .sel_b(sel_b2), .dis_a(dis_a2), .dis_b(dis_b2), .ex_valid(ex_valid2),
      .stall_out(stall_out2), .stall_cnt(stall_cnt2)
   );

   // Count one comparison and report it if it differs.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Which pipeline stage supplies register r: 1=EX, 2=MEM, 3=WB, 0=regfile.
   function automatic int src_of(input logic [4:0] r);
      if (r == 5'd0)                 return 0;
      if (ex_wr && ex_rd == r)       return 1;
      if (mem_wr && mem_rd == r)     return 2;
      if (wb_wr && wb_rd == r)       return 3;
      return 0;
   endfunction

   task automatic zero_inputs();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_imm_b = 0; id_shamt_a = 0; ex_wr = 0; ex_is_load = 0; ex_rd = 0;
      mem_wr = 0; mem_rd = 0; wb_wr = 0; wb_rd = 0; flush = 0;
   endtask

   task automatic rand_inputs();
      id_valid   = ($urandom_range(0, 7) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      id_imm_b   = ($urandom_range(0, 3) == 0);
      id_shamt_a = ($urandom_range(0, 3) == 0);
      ex_wr      = 1'($urandom);
      ex_is_load = 1'($urandom);
      ex_rd      = 5'($urandom_range(0, 3));
      mem_wr     = 1'($urandom);
      mem_rd     = 5'($urandom_range(0, 3));
      wb_wr      = 1'($urandom);
      wb_rd      = 5'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 7) == 0);
   endtask

   // Called just after a negedge with inputs applied: checks stall_out, then
   // the registered outputs after the following posedge.
   task automatic step();
      bit hz, take, uses_a, uses_b;
      int e_sa, e_sb, e_da, e_db, e_v;
      #1;
      uses_a = id_uses_rs && !id_shamt_a;
      uses_b = id_uses_rt && !id_imm_b;
      hz = !m_stall && id_valid && ex_wr && ex_is_load && ex_rd != 0 &&
           ((uses_a && id_rs == ex_rd) || (uses_b && id_rt == ex_rd));
      take = hz && !flush;
      check("stall_out", 32'(stall_out), 32'(take));
      e_sa = 0; e_sb = 0; e_da = 1; e_db = 1; e_v = 0;
      if (!flush && id_valid && !hz) begin
         e_v = 1;
         if (id_shamt_a)      begin e_sa = 5;              e_da = 0; end
         else if (id_uses_rs) begin e_sa = src_of(id_rs);  e_da = 0; end
         if (id_imm_b)        begin e_sb = 4;              e_db = 0; end
         else if (id_uses_rt) begin e_sb = src_of(id_rt);  e_db = 0; end
      end
      if (take) begin
         m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
         m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end
      m_stall = take;
      @(posedge clk);
      #1;
      check("sel_a",      32'(sel_a),      32'(e_sa));
      check("sel_b",      32'(sel_b),      32'(e_sb));
      check("dis_a",      32'(dis_a),      32'(e_da));
      check("dis_b",      32'(dis_b),      32'(e_db));
      check("ex_valid",   32'(ex_valid),   32'(e_v));
      check("stall_cnt",  32'(stall_cnt),  32'(m_cnt));
      check("stall_cnt2", 32'(stall_cnt2), 32'(m_cnt2));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sel_a"},    32'(sel_a),     32'(0));
      check({tag, "_sel_b"},    32'(sel_b),     32'(0));
      check({tag, "_dis_a"},    32'(dis_a),     32'(1));
      check({tag, "_dis_b"},    32'(dis_b),     32'(1));
      check({tag, "_ex_valid"}, 32'(ex_valid),  32'(0));
      check({tag, "_cnt"},      32'(stall_cnt), 32'(0));
      check({tag, "_stall"},    32'(stall_out), 32'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      zero_inputs();
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1;
      m_stall = 0; m_cnt = 0; m_cnt2 = 0;
   endtask

   task automatic load_use_b5();
      zero_inputs();
      id_valid = 1; id_rt = 5; id_uses_rt = 1; id_rs = 2; id_uses_rs = 1;
      ex_wr = 1; ex_is_load = 1; ex_rd = 5;
   endtask

   initial begin
      int exp_sat[4] = '{1, 2, 3, 3};
      rst_n = 0;
      zero_inputs();
      m_stall = 0; m_cnt = 0; m_cnt2 = 0;
      do_reset();

      // EX has priority over MEM
      zero_inputs();
      id_valid = 1; id_rs = 3; id_uses_rs = 1; ex_wr = 1; ex_rd = 3; mem_wr = 1; mem_rd = 3;
      step();
      check("d_ex_prio_sel", 32'(sel_a), 32'(1));
      check("d_ex_prio_dis", 32'(dis_a), 32'(0));
      check("d_ex_prio_v",   32'(ex_valid), 32'(1));

      // r0 never forwarded; immediate overrides rt match
      @(negedge clk);
      zero_inputs();
      id_valid = 1; id_rs = 0; id_uses_rs = 1; ex_wr = 1; ex_rd = 0;
      id_rt = 7; id_uses_rt = 1; id_imm_b = 1; mem_wr = 1; mem_rd = 7;
      step();
      check("d_r0_sel", 32'(sel_a), 32'(0));
      check("d_imm_sel", 32'(sel_b), 32'(4));

      // load-use: stall, bubble, then forward from MEM
      @(negedge clk);
      load_use_b5();
      #1;
      check("d_lu_stall", 32'(stall_out), 32'(1));
      step();
      check("d_lu_bubble_v", 32'(ex_valid), 32'(0));
      check("d_lu_bubble_d", 32'(dis_b), 32'(1));
      check("d_lu_cnt", 32'(stall_cnt), 32'(1));
      @(negedge clk);
      ex_wr = 0; ex_is_load = 0; ex_rd = 0; mem_wr = 1; mem_rd = 5;
      step();
      check("d_lu_mem_sel", 32'(sel_b), 32'(2));
      check("d_lu_mem_v", 32'(ex_valid), 32'(1));

      // flush overrides hazard, state stays RUN
      @(negedge clk);
      load_use_b5();
      flush = 1;
      step();
      check("d_fl_v", 32'(ex_valid), 32'(0));
      check("d_fl_cnt", 32'(stall_cnt), 32'(1));
      @(negedge clk);
      flush = 0;
      #1;
      check("d_fl_run", 32'(stall_out), 32'(1));
      step();

      // saturation of the 2-bit counter on back-to-back hazards
      do_reset();
      load_use_b5();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         step();
         if (i % 2 == 0) check("d_sat_cnt2", 32'(stall_cnt2), 32'(exp_sat[i / 2]));
      end

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rand_inputs();
         step();
      end

      // async reset while in STALL
      @(negedge clk);
      load_use_b5();
      step();
      check("d_in_stall", 32'(ex_valid), 32'(0));
      #2;
      rst_n = 0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1;
      m_stall = 0; m_cnt = 0; m_cnt2 = 0;
      step();

      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         rand_inputs();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
